// File: rtl/branch_pc_ctrl_pkg.sv
// Shared types and widths for the branch PC controller.
// The FSM state encoding and displacement sign extension live here.
package branch_pc_ctrl_pkg;

  localparam int PC_WIDTH = 32;
  localparam int C_WIDTH  = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [PC_WIDTH-1:0] sext_disp(input logic [C_WIDTH-1:0] c);
    return {{(PC_WIDTH - C_WIDTH){c[C_WIDTH-1]}}, c};
  endfunction

endpackage

// File: rtl/branch_pc_ctrl_pc_reg.sv
// Program counter register: relative add, direct load and increment.
// The caller gates the enables; add has priority, then load, then increment.
module pc_reg
  import branch_pc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                add_en,
  input  logic [PC_WIDTH-1:0] add_val,
  input  logic                load_en,
  input  logic [PC_WIDTH-1:0] load_val,
  input  logic                inc_en,
  output logic [PC_WIDTH-1:0] pc_q
);

  logic [PC_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (add_en) begin
      pc_d = pc_q + add_val;
    end else if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Branch sequencer: EVAL strobes the CON flip-flop, RESOLVE applies the
// sign-extended displacement when the condition holds, DONE pulses completion.
module branch_pc_ctrl
  import branch_pc_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [C_WIDTH-1:0]  ir_c,
  input  logic                con_flag,
  input  logic                pc_inc,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] bus_data,
  output logic                con_in,
  output logic [PC_WIDTH-1:0] pc_q,
  output logic                busy,
  output logic                taken,
  output logic                done
);

  state_t state_q, state_d;
  logic   taken_q, taken_d;
  logic   idle, resolve;
  logic   add_en, load_en, inc_en;

  assign idle    = (state_q == IDLE);
  assign resolve = (state_q == RESOLVE);

  // start owns the IDLE cycle it appears in, so PC requests then are dropped
  assign add_en  = resolve && con_flag;
  assign load_en = idle && !start && pc_load;
  assign inc_en  = idle && !start && !pc_load && pc_inc;

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    case (state_q)
      IDLE:    if (start) state_d = EVAL;
      EVAL:    state_d = RESOLVE;
      RESOLVE: begin
        taken_d = con_flag;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  pc_reg u_pc_reg (
    .clk      (clock),
    .rst      (clear),
    .add_en   (add_en),
    .add_val  (sext_disp(ir_c)),
    .load_en  (load_en),
    .load_val (bus_data),
    .inc_en   (inc_en),
    .pc_q     (pc_q)
  );

  assign con_in = (state_q == EVAL);
  assign busy   = !idle;
  assign done   = (state_q == DONE);
  assign taken  = taken_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed bench for branch_pc_ctrl: expected PC/taken pushed at start,
// popped and compared when done is observed.
module tb_branch_pc_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [18:0] ir_c;
  logic        con_flag;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] bus_data;
  logic        con_in;
  logic [31:0] pc_q;
  logic        busy;
  logic        taken;
  logic        done;

  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [31:0] model_pc;

  branch_pc_ctrl dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .ir_c     (ir_c),
    .con_flag (con_flag),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .bus_data (bus_data),
    .con_in   (con_in),
    .pc_q     (pc_q),
    .busy     (busy),
    .taken    (taken),
    .done     (done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_load  = 1'b1;
    bus_data = v;
    @(negedge clock);
    pc_load  = 1'b0;
    model_pc = v;
    check("pc_load", pc_q, v);
  endtask

  // lockout: drive pc_inc/pc_load/start while busy; prio: add them alongside start
  task automatic run_branch(input logic [18:0] ir, input logic flag,
                            input bit prio, input bit lockout);
    exp_t e;
    int   done_at;
    int   cnt0;
    e.tk = flag;
    e.pc = flag ? model_pc + {{13{ir[18]}}, ir} : model_pc;
    sb_q.push_back(e);
    ir_c     = ir;
    con_flag = flag;
    start    = 1'b1;
    if (prio) begin
      pc_load  = 1'b1;
      pc_inc   = 1'b1;
      bus_data = 32'h1234_5678;
    end
    cnt0    = done_cnt;
    done_at = 0;
    for (int k = 1; k <= 6 && done_at == 0; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
        check("eval_con_in", {31'd0, con_in}, 32'd1);
        check("eval_busy", {31'd0, busy}, 32'd1);
        check("eval_pc_hold", pc_q, model_pc);
        if (lockout) begin
          start = 1'b1; pc_load = 1'b1; pc_inc = 1'b1; bus_data = 32'hDEAD_0000;
        end
      end
      if (k == 2) begin
        check("resolve_con_in", {31'd0, con_in}, 32'd0);
        check("resolve_done", {31'd0, done}, 32'd0);
      end
      if (done) done_at = k;
      if (k == 2) begin
        start = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
      end
    end
    check("done_latency", done_at, 3);
    if (done_at != 0) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", pc_q, e.pc);
        check("sb_taken", {31'd0, taken}, {31'd0, e.tk});
        model_pc = e.pc;
      end
    end
    @(negedge clock);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clock);
    check("done_count", done_cnt - cnt0, 1);
    check("taken_hold", {31'd0, taken}, {31'd0, e.tk});
    $display("branch ir_c=0x%05h con_flag=%0d -> pc_q=0x%08h taken=%0d", ir, flag, pc_q, taken);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; ir_c = '0; con_flag = 1'b0;
    pc_inc = 1'b0; pc_load = 1'b0; bus_data = '0; model_pc = '0;
    #1;
    check("rst_pc", pc_q, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_con_in", {31'd0, con_in}, 32'd0);
    @(negedge clock); @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    // taken, not taken, negative wrap
    set_pc(32'h0000_0010);
    run_branch(19'h00005, 1'b1, 1'b0, 1'b0);
    set_pc(32'h0000_0010);
    run_branch(19'h7FFFF, 1'b0, 1'b0, 1'b0);
    set_pc(32'h0000_0002);
    run_branch(19'h7FFFD, 1'b1, 1'b0, 1'b0);

    // busy lockout
    set_pc(32'h0000_0100);
    run_branch(19'h00020, 1'b1, 1'b0, 1'b1);
    set_pc(32'h0000_0100);
    run_branch(19'h00020, 1'b0, 1'b0, 1'b1);

    // priority: start beats pc_load/pc_inc; pc_load beats pc_inc
    set_pc(32'h0000_0010);
    run_branch(19'h00004, 1'b0, 1'b1, 1'b0);
    pc_load = 1'b1; pc_inc = 1'b1; bus_data = 32'hCAFE_0000;
    @(negedge clock);
    pc_load = 1'b0; pc_inc = 1'b0;
    check("load_over_inc", pc_q, 32'hCAFE_0000);
    pc_inc = 1'b1;
    @(negedge clock);
    pc_inc = 1'b0;
    check("pc_inc", pc_q, 32'hCAFE_0001);
    set_pc(32'hFFFF_FFFF);
    pc_inc = 1'b1;
    @(negedge clock);
    pc_inc = 1'b0;
    check("inc_wrap", pc_q, 32'h0000_0000);

    // mid-sequence clear in RESOLVE
    set_pc(32'h0000_0040);
    run_branch(19'h00001, 1'b1, 1'b0, 1'b0);
    begin
      int cnt0;
      cnt0 = done_cnt;
      ir_c = 19'h00010; con_flag = 1'b1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check("pre_clr_resolve", {31'd0, busy}, 32'd1);
      #2 clear = 1'b1;
      #1;
      check("clr_pc", pc_q, 32'd0);
      check("clr_busy", {31'd0, busy}, 32'd0);
      check("clr_taken", {31'd0, taken}, 32'd0);
      check("clr_con_in", {31'd0, con_in}, 32'd0);
      @(negedge clock);
      clear = 1'b0;
      repeat (3) @(negedge clock);
      check("clr_no_done", done_cnt - cnt0, 0);
      check("clr_pc_hold", pc_q, 32'd0);
      model_pc = 32'd0;
    end
    run_branch(19'h00005, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
